mouse_event_gen: RTL and testbench

Parametrised mouse-event conditioner that sits in the display clock domain, directly after the mouse clock-domain-crossing buffer. It turns raw button levels into per-button press, release, double-click and long-press pulses plus a drag flag, clamps the cursor position to the visible area, and flags cursor movement. It is the generalised successor of the fixed left/right rising-edge detector. It adds any button count, configurable click timing and bounded coordinates.

---
 rtl/mouse_event_gen.sv | 199 +++++++++++++++++++
 tb/tb_mouse_event_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_event_gen.sv
// mouse_event_gen
// Conditions mouse inputs that have already been brought into the display
// clock domain. For each button it produces press, release, double-click and
// long-press pulses plus a drag level. The cursor position is clamped to the
// visible area, and a pulse flags each change of the clamped position.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   btn_in         raw button levels (bit 0 left, 1 right, 2 middle)
//   xpos_in/ypos_in raw cursor coordinates
//   press          one-cycle pulse per button press
//   release_evt    one-cycle pulse per button release. The port is not
//                  named "release" because that is a reserved word in
//                  SystemVerilog.
//   dbl_click      one-cycle pulse on the second press of a double-click
//   long_press     one-cycle pulse when a hold reaches HOLD_CYC
//   drag           button held and cursor moved since the press
//   xpos/ypos      clamped, registered position
//   move           one-cycle pulse when the clamped position changes
//
// Per-button FSM:
//   state   | meaning
//   S_IDLE  | no click in progress
//   S_DOWN1 | first press, counting towards long press
//   S_GAP   | released, waiting for a possible second press
//   S_DOWN2 | second press of a double-click, counting towards long press
//   S_HELD  | long press reported, waiting for release
module mouse_event_gen #(
  parameter int N_BTN    = 3,
  parameter int W        = 12,
  parameter int X_MAX    = 1023,
  parameter int Y_MAX    = 767,
  parameter int DBL_WIN  = 20,
  parameter int HOLD_CYC = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [W-1:0]     xpos_in,
  input  logic [W-1:0]     ypos_in,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_evt,
  output logic [N_BTN-1:0] dbl_click,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] drag,
  output logic [W-1:0]     xpos,
  output logic [W-1:0]     ypos,
  output logic             move
);

  localparam int CW_MAX = (DBL_WIN > HOLD_CYC) ? DBL_WIN : HOLD_CYC;
  localparam int CW     = $clog2(CW_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_WIN - 1);
  localparam logic [W-1:0]  X_LIM     = W'(X_MAX);
  localparam logic [W-1:0]  Y_LIM     = W'(Y_MAX);

  typedef enum logic [2:0] {S_IDLE, S_DOWN1, S_GAP, S_DOWN2, S_HELD} state_t;

  state_t          state_q [N_BTN];
  state_t          state_d [N_BTN];
  logic [CW-1:0]   cnt_q   [N_BTN];
  logic [CW-1:0]   cnt_d   [N_BTN];
  logic [W-1:0]    px_q    [N_BTN];
  logic [W-1:0]    px_d    [N_BTN];
  logic [W-1:0]    py_q    [N_BTN];
  logic [W-1:0]    py_d    [N_BTN];

  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] press_q, press_d, release_q, release_d;
  logic [N_BTN-1:0] dbl_q, dbl_d, long_q, long_d, drag_q, drag_d;
  logic [W-1:0]     xpos_q, xpos_d, ypos_q, ypos_d;
  logic             move_q, move_d;
  logic [N_BTN-1:0] rise, fall;

  always_comb begin
    rise = btn_in & ~btn_q;
    fall = ~btn_in & btn_q;

    xpos_d = (xpos_in > X_LIM) ? X_LIM : xpos_in;
    ypos_d = (ypos_in > Y_LIM) ? Y_LIM : ypos_in;
    move_d = (xpos_d != xpos_q) || (ypos_d != ypos_q);

    press_d   = '0;
    release_d = '0;
    dbl_d     = '0;
    long_d    = '0;
    drag_d    = '0;

    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      px_d[i]    = px_q[i];
      py_d[i]    = py_q[i];

      case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            press_d[i] = 1'b1;
            cnt_d[i]   = '0;
            px_d[i]    = xpos_q;
            py_d[i]    = ypos_q;
            state_d[i] = S_DOWN1;
          end
        end
        S_DOWN1, S_DOWN2: begin
          cnt_d[i] = cnt_q[i] + 1'b1;
          // A release on the terminal count wins over the long press.
          if (fall[i]) begin
            release_d[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = (state_q[i] == S_DOWN1) ? S_GAP : S_IDLE;
          end else if (cnt_q[i] == HOLD_LAST) begin
            long_d[i]  = 1'b1;
            state_d[i] = S_HELD;
          end
        end
        S_GAP: begin
          cnt_d[i] = cnt_q[i] + 1'b1;
          // A press on the last window cycle still counts as a double-click.
          if (rise[i]) begin
            press_d[i] = 1'b1;
            dbl_d[i]   = 1'b1;
            cnt_d[i]   = '0;
            px_d[i]    = xpos_q;
            py_d[i]    = ypos_q;
            state_d[i] = S_DOWN2;
          end else if (cnt_q[i] == DBL_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = S_IDLE;
          end
        end
        S_HELD: begin
          if (fall[i]) begin
            release_d[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = S_IDLE;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = S_IDLE;
        end
      endcase

      if ((state_q[i] == S_DOWN1 || state_q[i] == S_DOWN2 || state_q[i] == S_HELD)
          && !fall[i]
          && ((xpos_q != px_q[i]) || (ypos_q != py_q[i])))
        drag_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Ones here mean a button held through reset is not seen as a press.
      btn_q     <= '1;
      press_q   <= '0;
      release_q <= '0;
      dbl_q     <= '0;
      long_q    <= '0;
      drag_q    <= '0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      move_q    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        px_q[i]    <= '0;
        py_q[i]    <= '0;
      end
    end else begin
      btn_q     <= btn_in;
      press_q   <= press_d;
      release_q <= release_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
      drag_q    <= drag_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      move_q    <= move_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        px_q[i]    <= px_d[i];
        py_q[i]    <= py_d[i];
      end
    end
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign dbl_click   = dbl_q;
  assign long_press  = long_q;
  assign drag        = drag_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign move        = move_q;

endmodule

// File: tb/tb_mouse_event_gen.sv
module tb_mouse_event_gen;

  localparam int N_BTN = 3;
  localparam int W     = 12;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_in;
  logic [W-1:0]     xpos_in, ypos_in;
  logic [N_BTN-1:0] press, release_evt, dbl_click, long_press, drag;
  logic [W-1:0]     xpos, ypos;
  logic             move;

  int checks   = 0;
  int failures = 0;

  // Expected button outputs {press, release, dbl, long, drag} per step.
  logic [14:0] bexp_q[$];
  // Expected position outputs {xpos, ypos, move} per step.
  logic [24:0] pexp_q[$];

  mouse_event_gen #(
    .N_BTN(3), .W(12), .X_MAX(1023), .Y_MAX(767), .DBL_WIN(20), .HOLD_CYC(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .press(press), .release_evt(release_evt), .dbl_click(dbl_click),
    .long_press(long_press), .drag(drag), .xpos(xpos), .ypos(ypos), .move(move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] bv(input logic [2:0] p, input logic [2:0] r,
                                     input logic [2:0] d, input logic [2:0] l,
                                     input logic [2:0] g);
    return {p, r, d, l, g};
  endfunction

  task automatic test_reset();
    logic [14:0] got, act;
    rst_n = 1'b0; btn_in = '0; xpos_in = '0; ypos_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({press, release_evt, dbl_click, long_press, drag} !== 15'd0) begin
      failures++;
      $display("FAIL reset_btn: got %h want 0", {press, release_evt, dbl_click, long_press, drag});
    end
    checks++;
    if ({xpos, ypos, move} !== 25'd0) begin
      failures++;
      $display("FAIL reset_pos: got %h want 0", {xpos, ypos, move});
    end
    rst_n = 1'b1;
    bexp_q.push_back(15'd0);
    @(posedge clk); #1;
    got = bexp_q.pop_front();
    act = {press, release_evt, dbl_click, long_press, drag};
    checks++;
    if (act !== got) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", act, got);
    end
  endtask

  task automatic test_single_click();
    logic [14:0] got, act;
    for (int s = 0; s < 35; s++) begin
      bexp_q.push_back(bv({2'b0, s == 0}, {2'b0, s == 5}, 3'b0, 3'b0, 3'b0));
      btn_in = {2'b0, s < 5};
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL single_click step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  task automatic test_double_click(input int g, input logic want_dbl);
    logic [14:0] got, act;
    logic        b;
    for (int s = 0; s < 40 + g; s++) begin
      b = (s < 5) || (s >= 5 + g && s < 10 + g);
      bexp_q.push_back(bv({2'b0, s == 0 || s == 5 + g},
                          {2'b0, s == 5 || s == 10 + g},
                          {2'b0, want_dbl && s == 5 + g}, 3'b0, 3'b0));
      btn_in = {2'b0, b};
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL double_click gap %0d step %0d: got %h want %h", g, s, act, got);
      end
    end
  endtask

  task automatic test_long_press();
    logic [14:0] got, act;
    logic        b;
    for (int s = 0; s < 96; s++) begin
      b = (s < 60) || (s >= 63 && s < 66);
      bexp_q.push_back(bv({1'b0, s == 0 || s == 63, 1'b0},
                          {1'b0, s == 60 || s == 66, 1'b0},
                          3'b0, {1'b0, s == 40, 1'b0}, 3'b0));
      btn_in = {1'b0, b, 1'b0};
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL long_press step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got, act;
    for (int s = 0; s < 28; s++) begin
      bexp_q.push_back(bv((s == 0) ? 3'b101 : 3'b000, (s == 3) ? 3'b101 : 3'b000,
                          3'b0, 3'b0, 3'b0));
      btn_in = (s < 3) ? 3'b101 : 3'b000;
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  task automatic test_clamp_move();
    logic [24:0] got, act;
    logic [11:0] xi [6];
    logic [11:0] yi [6];
    logic [24:0] ex [6];
    xi = '{12'd2000, 12'd2000, 12'd1500, 12'd4095, 12'd100, 12'd100};
    yi = '{12'd500,  12'd500,  12'd500,  12'd4095, 12'd100, 12'd100};
    ex = '{{12'd1023, 12'd500, 1'b1}, {12'd1023, 12'd500, 1'b0},
           {12'd1023, 12'd500, 1'b0}, {12'd1023, 12'd767, 1'b1},
           {12'd100,  12'd100, 1'b1}, {12'd100,  12'd100, 1'b0}};
    for (int s = 0; s < 6; s++) begin
      pexp_q.push_back(ex[s]);
      xpos_in = xi[s]; ypos_in = yi[s];
      @(posedge clk); #1;
      got = pexp_q.pop_front();
      act = {xpos, ypos, move};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL clamp_move step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  task automatic test_drag();
    logic [14:0] got, act;
    logic [24:0] pgot, pact;
    logic [11:0] xe;
    for (int s = 0; s < 36; s++) begin
      xe = (s >= 2) ? 12'd101 : 12'd100;
      bexp_q.push_back(bv({2'b0, s == 0}, {2'b0, s == 6}, 3'b0, 3'b0,
                          {2'b0, s >= 3 && s < 6}));
      pexp_q.push_back({xe, 12'd100, s == 2});
      btn_in = {2'b0, s < 6};
      xpos_in = xe; ypos_in = 12'd100;
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL drag_btn step %0d: got %h want %h", s, act, got);
      end
      pgot = pexp_q.pop_front();
      pact = {xpos, ypos, move};
      checks++;
      if (pact !== pgot) begin
        failures++;
        $display("FAIL drag_pos step %0d: got %h want %h", s, pact, pgot);
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic [14:0] got, act;
    rst_n = 1'b0; btn_in = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({press, release_evt, dbl_click, long_press, drag, xpos, ypos, move} !== 40'd0) begin
      failures++;
      $display("FAIL held_reset_zero: got %h want 0",
               {press, release_evt, dbl_click, long_press, drag, xpos, ypos, move});
    end
    rst_n = 1'b1;
    for (int s = 0; s < 40; s++) begin
      bexp_q.push_back(bv((s == 8) ? 3'b100 : 3'b000, (s == 10) ? 3'b100 : 3'b000,
                          3'b0, 3'b0, 3'b0));
      btn_in = (s < 5) ? 3'b111 : (s < 8) ? 3'b011 : (s < 10) ? 3'b111 : 3'b000;
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL held_reset step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  task automatic test_reset_in_gap();
    logic [14:0] got, act;
    for (int s = 0; s < 5; s++) begin
      bexp_q.push_back(bv({2'b0, s == 0}, {2'b0, s == 3}, 3'b0, 3'b0, 3'b0));
      btn_in = {2'b0, s < 3};
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL gap_click step %0d: got %h want %h", s, act, got);
      end
    end
    rst_n = 1'b0; btn_in = 3'b001;
    @(posedge clk); #1;
    checks++;
    if ({press, release_evt, dbl_click, long_press, drag, xpos, ypos, move} !== 40'd0) begin
      failures++;
      $display("FAIL gap_reset_zero: got %h want 0",
               {press, release_evt, dbl_click, long_press, drag, xpos, ypos, move});
    end
    rst_n = 1'b1; btn_in = 3'b000;
    pexp_q.push_back({12'd101, 12'd100, 1'b1});
    @(posedge clk); #1;
    checks++;
    if ({xpos, ypos, move} !== pexp_q.pop_front()) begin
      failures++;
      $display("FAIL post_reset_move: got %h want %h", {xpos, ypos, move},
               {12'd101, 12'd100, 1'b1});
    end
    for (int s = 0; s < 34; s++) begin
      bexp_q.push_back(bv({2'b0, s == 0}, {2'b0, s == 2}, 3'b0, 3'b0, 3'b0));
      btn_in = {2'b0, s < 2};
      @(posedge clk); #1;
      got = bexp_q.pop_front();
      act = {press, release_evt, dbl_click, long_press, drag};
      checks++;
      if (act !== got) begin
        failures++;
        $display("FAIL post_reset_click step %0d: got %h want %h", s, act, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_double_click(10, 1'b1);
    test_double_click(19, 1'b1);
    test_double_click(21, 1'b0);
    test_long_press();
    test_back_to_back();
    test_clamp_move();
    test_drag();
    test_held_through_reset();
    test_reset_in_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
